// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM states and register-index constants for pipeline control.
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: ID-stage RAW hazard against EXE/MEM destinations, with or without forwarding.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int W = REG_W
) (
  input  logic         fwd_en,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic         two_src,
  input  logic [W-1:0] exe_dest,
  input  logic         exe_wb_en,
  input  logic         exe_mem_read,
  input  logic [W-1:0] mem_dest,
  input  logic         mem_wb_en,
  output logic         hz
);
  logic s1_ok, s2_ok, exe_hit, mem_hit;
  // x0 is hardwired, so a zero source never depends on anything.
  assign s1_ok   = src1 != W'(REG_ZERO);
  assign s2_ok   = two_src && src2 != W'(REG_ZERO);
  assign exe_hit = exe_wb_en && ((s1_ok && src1 == exe_dest) || (s2_ok && src2 == exe_dest));
  assign mem_hit = mem_wb_en && ((s1_ok && src1 == mem_dest) || (s2_ok && src2 == mem_dest));
  assign hz      = fwd_en ? exe_hit && exe_mem_read : exe_hit || mem_hit;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: merges data hazards, taken branches and SRAM waits into one
// per-cycle stall/flush control word for the 5-stage pipeline.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W     = pipe_ctrl_pkg::REG_W,
  parameter int SRAM_WAIT = 6,
  parameter int CNT_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             branch_taken,
  output logic             pc_freez,
  output logic             ifid_freez,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freez,
  output logic             mem_ready,
  output logic             busy
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic hz, frz, bh;

  hazard_detect #(.W(REG_W)) u_hz (
    .fwd_en(fwd_en),
    .src1(id_src1),
    .src2(id_src2),
    .two_src(id_two_src),
    .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en),
    .hz(hz)
  );

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  // RELEASE ignores mem_req so the access just completed is never restarted.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    frz       = (state == ST_RUN && mem_req) || state == ST_WAIT;
    bh        = !frz;
    state_nxt = state == ST_RUN  ? (mem_req ? (SRAM_WAIT == 1 ? ST_RELEASE : ST_WAIT) : ST_RUN) :
                state == ST_WAIT ? (cnt == CNT_W'(1) ? ST_RELEASE : ST_WAIT) : ST_RUN;
    cnt_nxt   = state == ST_RUN && mem_req ? CNT_W'(SRAM_WAIT - 1) :
                state == ST_WAIT ? cnt - 1'b1 : cnt;
    pipe_freez = !reset && frz;
    pc_freez   = !reset && (frz || (bh && !branch_taken && hz));
    ifid_freez = !reset && (frz || (bh && !branch_taken && hz));
    ifid_flush = !reset && bh && branch_taken;
    idex_flush = !reset && bh && (branch_taken || hz);
    mem_ready  = !reset && state == ST_RELEASE;
    busy       = !reset && state != ST_RUN;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives freez/flush of the PC, the IF/ID register and the ID/EX register.
- Freezes the whole pipeline for a fixed number of cycles on every MEM-stage SRAM access.
- Combines three causes into one consistent control word per cycle: load-use/data hazards (with or without forwarding), taken branches and multi-cycle memory waits.

Parameters:
- REG_W, 5, register index width.
- SRAM_WAIT, 6, freeze cycles per MEM access; legal range 1..15.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > SRAM_WAIT.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  async active-high reset.
- fwd_en  in  1  forwarding unit enabled.
- id_src1  in  REG_W  ID-stage source register 1.
- id_src2  in  REG_W  ID-stage source register 2.
- id_two_src  in  1  ID instruction reads src2.
- exe_dest  in  REG_W  EXE-stage destination.
- exe_wb_en  in  1  EXE writes back.
- exe_mem_read  in  1  EXE is a load.
- mem_dest  in  REG_W  MEM-stage destination.
- mem_wb_en  in  1  MEM writes back.
- mem_req  in  1  MEM-stage instruction accesses SRAM; held high while that instruction sits in MEM.
- branch_taken  in  1  EXE resolved a taken branch.
- pc_freez  out  1  hold PC.
- ifid_freez  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX (insert bubble).
- pipe_freez  out  1  hold all pipeline registers and PC (memory wait).
- mem_ready  out  1  SRAM data valid this cycle.
- busy  out  1  state != RUN.

Behaviour:
- States: RUN, WAIT, RELEASE. Registered state plus a CNT_W-bit down-counter cnt.
- Reset (async): state=RUN, cnt=0. While reset is high, all outputs are forced to 0 combinationally.
- Reset mid-WAIT aborts the access; after release the FSM restarts in RUN.
- All outputs are combinational functions of state, cnt and inputs (same-cycle effect).
- Hazard term (hz), computed combinationally; register index 0 never matches:
  - src2 participates only if id_two_src.
  - fwd_en=0: hz = a src matches exe_dest with exe_wb_en, OR a src matches mem_dest with mem_wb_en.
  - fwd_en=1: hz = a src matches exe_dest with exe_wb_en AND exe_mem_read (load-use only).
- RUN with mem_req=1:
  - Outputs: pipe_freez=1, pc_freez=1, ifid_freez=1, all flushes=0.
  - cnt <= SRAM_WAIT-1.
  - Next state: RELEASE if SRAM_WAIT==1, else WAIT.
- WAIT:
  - Outputs: pipe_freez=1, pc_freez=1, ifid_freez=1, flushes=0.
  - cnt <= cnt-1; when cnt==1, next state is RELEASE.
  - branch_taken and hz are ignored; EXE is frozen, so they are re-evaluated at RELEASE.
- RELEASE:
  - mem_ready=1, pipe_freez=0; next state RUN unconditionally.
  - mem_req is ignored here, so the same access is never restarted.
  - Branch/hazard rules below apply.
- Net effect: pipe_freez is high for exactly SRAM_WAIT consecutive cycles per access, followed by one mem_ready cycle.
- Branch/hazard rules, in RUN without mem_req and in RELEASE, in priority order:
  1. branch_taken=1: ifid_flush=1, idex_flush=1, no freezes. Branch overrides hz because the ID instruction is wrong-path.
  2. else hz=1: pc_freez=1, ifid_freez=1, idex_flush=1.
  3. else: all outputs 0.
- Back-to-back accesses: mem_req high on the cycle after RELEASE, with a new instruction now in MEM, starts a fresh wait.
- busy=1 in WAIT and RELEASE.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum ST_RUN=2'd0, ST_WAIT=2'd1, ST_RELEASE=2'd2;
  - REG_W, and constant REG_ZERO.
- One natural combinational sub-module, hazard_detect, produces hz from the src/dest/enable/fwd_en inputs and is reused by the forwarding-disabled build.

Test Plan:
- Load-use, fwd_en=1: exe_dest=3, exe_mem_read=1, exe_wb_en=1, id_src1=3 -> pc_freez=ifid_freez=idex_flush=1 for one cycle. Same stimulus with exe_mem_read=0 -> all outputs 0.
- fwd_en=0, mem_dest=7, mem_wb_en=1, id_two_src=1, id_src2=7 -> stall. With id_two_src=0 -> no stall. dest=0 with id_src1=0 -> no stall.
- branch_taken=1 together with hz=1 -> ifid_flush=idex_flush=1, pc_freez=0, ifid_freez=0.
- SRAM_WAIT=6, mem_req held 7 cycles -> pipe_freez high cycles 0-5, mem_ready high cycle 6, busy high cycles 1-6, state RUN on cycle 7. Repeat with SRAM_WAIT=1 -> 1 freeze cycle, then mem_ready.
- branch_taken asserted during WAIT -> no flush until RELEASE, then ifid_flush=idex_flush=1 together with mem_ready=1.
- reset pulsed at WAIT cycle 3 -> outputs 0 immediately, state=RUN, cnt=0. mem_req after reset -> full 6-cycle freeze.
